// File: rtl/crf_lite_master.sv
// AXI4-Lite master: turns one register command at a time into a single AXI4-Lite
// write or read, returns the response, and flags a slave that never answers.
module crf_lite_master #(
    parameter int         AXI_DATA_WIDTH = 32,
    parameter int         AXI_ADDR_WIDTH = 32,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [2:0] PROT_VALUE     = 3'b000
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_write,
    output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                    rsp_resp,

    output logic                          timeout_err,
    output logic                          busy,

    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    input  logic [1:0]                    m_axi_bresp,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD,
        RD_DATA,
        RSP
    } state_t;

    state_t                      state;
    logic [CNT_W-1:0]            wd_cnt;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic                        waiting;
    logic                        aw_clear;
    logic                        w_clear;

    assign cmd_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_awprot = PROT_VALUE;
    assign m_axi_arprot = PROT_VALUE;

    assign waiting  = (state == WR) || (state == WR_RESP) || (state == RD) || (state == RD_DATA);
    // A channel counts as done if it already finished or is handshaking this cycle
    assign aw_clear = !m_axi_awvalid || m_axi_awready;
    assign w_clear  = !m_axi_wvalid  || m_axi_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wd_cnt        <= '0;
            timeout_err   <= 1'b0;
            addr_q        <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
        end else begin
            // Watchdog saturates; valid can never be withdrawn, so the FSM keeps waiting
            if (waiting && wd_cnt == CNT_MAX) begin
                timeout_err <= 1'b1;
            end
            if (waiting && wd_cnt != CNT_MAX) begin
                wd_cnt <= wd_cnt + CNT_ONE;
            end

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q <= cmd_addr;
                        wd_cnt <= '0;
                        if (cmd_write) begin
                            m_axi_wdata   <= cmd_wdata;
                            m_axi_wstrb   <= cmd_wstrb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WR;
                        end else begin
                            m_axi_arvalid <= 1'b1;
                            state         <= RD;
                        end
                    end
                end
                WR: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                    end
                    if (m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                    end
                    if (aw_clear && w_clear) begin
                        m_axi_bready <= 1'b1;
                        wd_cnt       <= '0;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        rsp_write    <= 1'b1;
                        rsp_rdata    <= '0;
                        rsp_resp     <= m_axi_bresp;
                        rsp_valid    <= 1'b1;
                        wd_cnt       <= '0;
                        state        <= RSP;
                    end
                end
                RD: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        wd_cnt        <= '0;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_write    <= 1'b0;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        rsp_valid    <= 1'b1;
                        wd_cnt       <= '0;
                        state        <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crf_lite_master.sv
// Self-checking bench for crf_lite_master: a delay-programmable AXI4-Lite slave
// model, a table of directed transactions, and hand-written corner-case sequences.
module tb_crf_lite_master;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_wstrb;
    logic            rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            timeout_err, busy;
    logic            m_axi_awvalid, m_axi_awready;
    logic [AW-1:0]   m_axi_awaddr;
    logic [2:0]      m_axi_awprot;
    logic            m_axi_wvalid, m_axi_wready;
    logic [DW-1:0]   m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_bvalid, m_axi_bready;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_arvalid, m_axi_arready;
    logic [AW-1:0]   m_axi_araddr;
    logic [2:0]      m_axi_arprot;
    logic            m_axi_rvalid, m_axi_rready;
    logic [DW-1:0]   m_axi_rdata;
    logic [1:0]      m_axi_rresp;

    crf_lite_master #(
        .AXI_DATA_WIDTH(DW),
        .AXI_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TMO),
        .PROT_VALUE(3'b000)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .timeout_err(timeout_err), .busy(busy),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
    );

    always #5 clk = ~clk;

    // Slave model: each ready/valid comes up after a programmable number of waiting cycles
    int            aw_dly, w_dly, b_dly, ar_dly, r_dly;
    int            aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic          aw_seen, w_seen, ar_seen;
    int            b_hs_cnt, r_hs_cnt;
    logic [AW-1:0] cap_awaddr, cap_araddr;
    logic [DW-1:0] cap_wdata;
    logic [3:0]    cap_wstrb;
    logic [1:0]    s_bresp, s_rresp;
    logic [DW-1:0] s_rdata;

    assign m_axi_awready = (aw_wait >= aw_dly) && !aw_seen;
    assign m_axi_wready  = (w_wait >= w_dly) && !w_seen;
    assign m_axi_bvalid  = aw_seen && w_seen && (b_wait >= b_dly);
    assign m_axi_bresp   = s_bresp;
    assign m_axi_arready = (ar_wait >= ar_dly) && !ar_seen;
    assign m_axi_rvalid  = ar_seen && (r_wait >= r_dly);
    assign m_axi_rdata   = s_rdata;
    assign m_axi_rresp   = s_rresp;

    always @(posedge clk) begin
        if (rst) begin
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
            aw_seen <= 1'b0; w_seen <= 1'b0; ar_seen <= 1'b0;
            b_hs_cnt <= 0; r_hs_cnt <= 0;
            cap_awaddr <= '0; cap_araddr <= '0; cap_wdata <= '0; cap_wstrb <= '0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin
                aw_seen <= 1'b1; aw_wait <= 0; cap_awaddr <= m_axi_awaddr;
            end else if (m_axi_awvalid) begin
                aw_wait <= aw_wait + 1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_seen <= 1'b1; w_wait <= 0; cap_wdata <= m_axi_wdata; cap_wstrb <= m_axi_wstrb;
            end else if (m_axi_wvalid) begin
                w_wait <= w_wait + 1;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                aw_seen <= 1'b0; w_seen <= 1'b0; b_wait <= 0; b_hs_cnt <= b_hs_cnt + 1;
            end else if (aw_seen && w_seen) begin
                b_wait <= b_wait + 1;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                ar_seen <= 1'b1; ar_wait <= 0; cap_araddr <= m_axi_araddr;
            end else if (m_axi_arvalid) begin
                ar_wait <= ar_wait + 1;
            end
            if (m_axi_rvalid && m_axi_rready) begin
                ar_seen <= 1'b0; r_wait <= 0; r_hs_cnt <= r_hs_cnt + 1;
            end else if (ar_seen) begin
                r_wait <= r_wait + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    // Word-sized comparison; narrower fields are widened by the caller
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkFlag(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Presents a command from a falling edge and returns on the falling edge after acceptance
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb);
        bit accepted;
        accepted  = 1'b0;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = strb;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            if (cmd_ready) accepted = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (!accepted) checkFlag("cmd_accept", 1'b0, 1'b1);
    endtask

    task automatic finishResponse(input string tag, input logic exp_wr,
                                  input logic [31:0] exp_rdata, input logic [1:0] exp_resp,
                                  input int max_cycles);
        int n;
        n = 0;
        while (!rsp_valid && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            checkFlag({tag, " rsp_wait"}, 1'b0, 1'b1);
            return;
        end
        checkFlag({tag, " rsp_write"}, rsp_write, exp_wr);
        checkOutput({tag, " rsp_rdata"}, rsp_rdata, exp_rdata);
        checkOutput({tag, " rsp_resp"}, 32'(rsp_resp), 32'(exp_resp));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkFlag({tag, " rsp_dropped"}, rsp_valid, 1'b0);
        checkFlag({tag, " idle_ready"}, cmd_ready, 1'b1);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]  sresp;
        logic [31:0] srdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int b0, r0;

        vecs[0] = '{1'b1, 32'h04, 32'h0000_0001, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b00};
        vecs[1] = '{1'b1, 32'h10, 32'hCAFE_F00D, 4'h5, 0, 6, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b00};
        vecs[2] = '{1'b1, 32'h14, 32'h1234_5678, 4'h3, 6, 0, 2, 0, 0, 2'b10, 32'h0, 32'h0, 2'b10};
        vecs[3] = '{1'b0, 32'h08, 32'h0,         4'h0, 0, 0, 0, 0, 3, 2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b10};
        vecs[4] = '{1'b0, 32'h0C, 32'h0,         4'h0, 0, 0, 0, 4, 0, 2'b00, 32'hA5A5_0001, 32'hA5A5_0001, 2'b00};
        vecs[5] = '{1'b1, 32'h1F, 32'hFFFF_0000, 4'h8, 3, 3, 0, 0, 0, 2'b01, 32'h0, 32'h0, 2'b01};
        vecs[6] = '{1'b0, 32'h20, 32'h0,         4'h0, 0, 0, 0, 2, 1, 2'b00, 32'h0000_0042, 32'h0000_0042, 2'b00};

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        s_bresp = 2'b00; s_rresp = 2'b00; s_rdata = '0;
        repeat (3) @(negedge clk);

        checkFlag("reset cmd_ready", cmd_ready, 1'b1);
        checkFlag("reset busy", busy, 1'b0);
        checkFlag("reset awvalid", m_axi_awvalid, 1'b0);
        checkFlag("reset wvalid", m_axi_wvalid, 1'b0);
        checkFlag("reset arvalid", m_axi_arvalid, 1'b0);
        checkFlag("reset bready", m_axi_bready, 1'b0);
        checkFlag("reset rready", m_axi_rready, 1'b0);
        checkFlag("reset rsp_valid", rsp_valid, 1'b0);
        checkFlag("reset timeout_err", timeout_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait write: AW/W at N+1, bready at N+2, response at N+3
        applyStimulus(1'b1, 32'h04, 32'h0000_0001, 4'hF);
        checkFlag("t1 awvalid N+1", m_axi_awvalid, 1'b1);
        checkFlag("t1 wvalid N+1", m_axi_wvalid, 1'b1);
        checkOutput("t1 awaddr", m_axi_awaddr, 32'h04);
        checkOutput("t1 wdata", m_axi_wdata, 32'h1);
        checkFlag("t1 bready N+1", m_axi_bready, 1'b0);
        checkFlag("t1 busy", busy, 1'b1);
        checkFlag("t1 cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        checkFlag("t1 bready N+2", m_axi_bready, 1'b1);
        checkFlag("t1 awvalid N+2", m_axi_awvalid, 1'b0);
        checkFlag("t1 wvalid N+2", m_axi_wvalid, 1'b0);
        checkFlag("t1 rsp_valid N+2", rsp_valid, 1'b0);
        @(negedge clk);
        checkFlag("t1 rsp_valid N+3", rsp_valid, 1'b1);
        finishResponse("t1", 1'b1, 32'h0, 2'b00, 0);

        // Table of directed transactions with assorted slave delays
        for (int i = 0; i < 7; i++) begin
            aw_dly = vecs[i].aw_d; w_dly = vecs[i].w_d; b_dly = vecs[i].b_d;
            ar_dly = vecs[i].ar_d; r_dly = vecs[i].r_d;
            s_bresp = vecs[i].sresp; s_rresp = vecs[i].sresp; s_rdata = vecs[i].srdata;
            b0 = b_hs_cnt; r0 = r_hs_cnt;
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            finishResponse($sformatf("vec%0d", i), vecs[i].wr, vecs[i].exp_rdata, vecs[i].exp_resp, 40);
            if (vecs[i].wr) begin
                checkOutput($sformatf("vec%0d awaddr", i), cap_awaddr, vecs[i].addr);
                checkOutput($sformatf("vec%0d wdata", i), cap_wdata, vecs[i].wdata);
                checkOutput($sformatf("vec%0d wstrb", i), 32'(cap_wstrb), 32'(vecs[i].strb));
                checkOutput($sformatf("vec%0d b_count", i), 32'(b_hs_cnt - b0), 32'd1);
            end else begin
                checkOutput($sformatf("vec%0d araddr", i), cap_araddr, vecs[i].addr);
                checkOutput($sformatf("vec%0d r_count", i), 32'(r_hs_cnt - r0), 32'd1);
            end
            checkFlag($sformatf("vec%0d timeout_err", i), timeout_err, 1'b0);
        end

        // W stalled behind an early AW: awvalid drops, wvalid and wdata hold
        aw_dly = 0; w_dly = 6; b_dly = 0; s_bresp = 2'b00;
        b0 = b_hs_cnt;
        applyStimulus(1'b1, 32'h24, 32'h0F0F_1234, 4'hF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkFlag($sformatf("t2a awvalid c%0d", k), m_axi_awvalid, 1'b0);
            checkFlag($sformatf("t2a wvalid c%0d", k), m_axi_wvalid, 1'b1);
            checkOutput($sformatf("t2a wdata c%0d", k), m_axi_wdata, 32'h0F0F_1234);
        end
        finishResponse("t2a", 1'b1, 32'h0, 2'b00, 20);
        checkOutput("t2a b_count", 32'(b_hs_cnt - b0), 32'd1);

        // AW stalled behind an early W
        aw_dly = 6; w_dly = 0;
        b0 = b_hs_cnt;
        applyStimulus(1'b1, 32'h28, 32'h0000_BEEF, 4'hC);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkFlag($sformatf("t2b wvalid c%0d", k), m_axi_wvalid, 1'b0);
            checkFlag($sformatf("t2b awvalid c%0d", k), m_axi_awvalid, 1'b1);
            checkOutput($sformatf("t2b awaddr c%0d", k), m_axi_awaddr, 32'h28);
        end
        finishResponse("t2b", 1'b1, 32'h0, 2'b00, 20);
        checkOutput("t2b b_count", 32'(b_hs_cnt - b0), 32'd1);

        // Response back-pressure: second command waits for the IDLE cycle
        aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0;
        s_rdata = 32'h0BAD_C0DE; s_rresp = 2'b00;
        applyStimulus(1'b0, 32'h08, 32'h0, 4'h0);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h55; cmd_wstrb = 4'hF;
        cmd_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checkFlag($sformatf("t4 rsp_valid c%0d", k), rsp_valid, 1'b1);
            checkOutput($sformatf("t4 rsp_rdata c%0d", k), rsp_rdata, 32'h0BAD_C0DE);
            checkFlag($sformatf("t4 cmd_ready c%0d", k), cmd_ready, 1'b0);
            checkFlag($sformatf("t4 awvalid c%0d", k), m_axi_awvalid, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkFlag("t4 rsp_dropped", rsp_valid, 1'b0);
        checkFlag("t4 idle cmd_ready", cmd_ready, 1'b1);
        checkFlag("t4 idle awvalid", m_axi_awvalid, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkFlag("t4 second awvalid", m_axi_awvalid, 1'b1);
        checkOutput("t4 second awaddr", m_axi_awaddr, 32'h30);
        finishResponse("t4 second", 1'b1, 32'h0, 2'b00, 20);

        // Watchdog: arready withheld, flag rises after 16 cycles in RD
        ar_dly = 1000; r_dly = 0; s_rdata = 32'h600D_600D; s_rresp = 2'b00;
        applyStimulus(1'b0, 32'h40, 32'h0, 4'h0);
        repeat (15) @(negedge clk);
        checkFlag("t5 timeout_err N+16", timeout_err, 1'b0);
        checkFlag("t5 arvalid N+16", m_axi_arvalid, 1'b1);
        @(negedge clk);
        checkFlag("t5 timeout_err N+17", timeout_err, 1'b1);
        checkFlag("t5 arvalid N+17", m_axi_arvalid, 1'b1);
        checkFlag("t5 busy", busy, 1'b1);
        checkOutput("t5 araddr", m_axi_araddr, 32'h40);
        ar_dly = 0;
        finishResponse("t5", 1'b0, 32'h600D_600D, 2'b00, 10);
        checkFlag("t5 timeout_err sticky", timeout_err, 1'b1);

        // Reset while waiting for B abandons the write and clears the flag
        ar_dly = 0; b_dly = 20;
        applyStimulus(1'b1, 32'h50, 32'h1111_2222, 4'hF);
        @(negedge clk);
        checkFlag("t6 bready in WR_RESP", m_axi_bready, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        checkFlag("t6 awvalid", m_axi_awvalid, 1'b0);
        checkFlag("t6 wvalid", m_axi_wvalid, 1'b0);
        checkFlag("t6 bready", m_axi_bready, 1'b0);
        checkFlag("t6 arvalid", m_axi_arvalid, 1'b0);
        checkFlag("t6 rready", m_axi_rready, 1'b0);
        checkFlag("t6 rsp_valid", rsp_valid, 1'b0);
        checkFlag("t6 cmd_ready", cmd_ready, 1'b1);
        checkFlag("t6 busy", busy, 1'b0);
        checkFlag("t6 timeout_err", timeout_err, 1'b0);
        rst = 1'b0;
        b_dly = 0; s_bresp = 2'b00;
        @(negedge clk);
        b0 = b_hs_cnt;
        applyStimulus(1'b1, 32'h54, 32'h0000_0077, 4'hF);
        finishResponse("t6 after", 1'b1, 32'h0, 2'b00, 20);
        checkOutput("t6 after awaddr", cap_awaddr, 32'h54);
        checkOutput("t6 after wdata", cap_wdata, 32'h77);
        checkOutput("t6 after b_count", 32'(b_hs_cnt - b0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
